keccak_round_sequencer: RTL
===========================

// Module: keccak_round_sequencer
// PURPOSE
//  Drives the permutation round loop of the low-throughput SHA-3 core. Accepts one start per
//  permutation and steps a one-hot round index through all rounds, one per enabled cycle.
//  The index feeds the round-constant generator and the permutation datapath.
//  Signals completion with a valid/ready handshake to the padder/output stage.
// PARAMETERS
//  ROUNDS  24  number of permutation rounds; equals the width of the one-hot round index
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  reset         in   1       synchronous, active-high reset
//  start_valid   in   1       request to begin a permutation
//  start_ready   out  1       sequencer can accept start (IDLE only)
//  stall         in   1       freeze round stepping while in RUN (datapath back-pressure)
//  abort         in   1       cancel current permutation, return to IDLE
//  round_onehot  out  ROUNDS  one-hot round index (bit k = round k); all-zero outside RUN
//  round_en      out  1       datapath applies one round this cycle
//  round_first   out  1       round_onehot[0] & round_en
//  round_last    out  1       round_onehot[ROUNDS-1] & round_en
//  busy          out  1       state != IDLE
//  done_valid    out  1       permutation complete, result stable in datapath
//  done_ready    in   1       consumer has taken the result
// BEHAVIOUR
//  - Reset: the reset behaviour and timing are fixed. Clock and reset port names are clk and
//    reset. Reset is synchronous and active-high.
//  - Reset values: state=IDLE, round_onehot=0, done_valid=0, round_en=0, busy=0,
//    start_ready=1 (first cycle after reset).
//  - A reset asserted mid-RUN or in DONE discards all progress. There is no pending done.
//  - State machine: IDLE, RUN, DONE (2-bit encoding). round_onehot is a registered state.
//    Every other output decodes combinationally from state and round_onehot (and stall).
//  - IDLE: start_ready=1.
//    - start_valid=1 -> RUN next cycle with round_onehot=1 (bit 0).
//    - start_valid=0 -> stay in IDLE.
//  - RUN: round_en = ~stall.
//    - If round_en: round_onehot shifts left by 1 on each edge.
//    - If stall=1: round_onehot holds.
//    - round_en with round_onehot[ROUNDS-1]=1 -> DONE next cycle, round_onehot cleared to 0.
//  - DONE: done_valid=1, held until done_ready=1. The handshake cycle moves to IDLE on the
//    next edge. done_ready is ignored outside DONE.
//    - start_ready=0 in DONE. No start is accepted in the same cycle as the done handshake.
//  - Latency with no stalls:
//    - start accepted at cycle T -> round 0 at T+1, round ROUNDS-1 at T+ROUNDS.
//    - done_valid at T+ROUNDS+1. Each stall cycle adds exactly 1 cycle.
//  - abort (any state) -> IDLE next edge, round_onehot=0, done_valid drops without a
//    handshake.
//    - abort has priority over start_valid, stall and done_ready.
//    - round_en still equals ~stall in an abort cycle. The datapath ignores that round.
//  - Index invariant: round_onehot is exactly one-hot in RUN and all-zero otherwise.
//    - A zero index makes the round-constant generator output 0.
//    - A non-one-hot value must be impossible from any reachable state.
//  - Stall in IDLE or DONE has no effect. round_en=0 outside RUN.
//  - Widths: no counter arithmetic. The shift is within ROUNDS bits and never wraps;
//    the exit to DONE happens before any wrap.
// TESTING
//  1. Reset, then start_valid pulse at T (ROUNDS=24) ->
//     - round_onehot = 1<<k at T+1+k for k=0..23, with round_first at T+1 and round_last
//       at T+24.
//     - done_valid at T+25, held 3 cycles until done_ready, IDLE at T+29.
//  2. Stall high for 5 cycles while round_onehot=0x000100 ->
//     - round_onehot holds 0x000100 and round_en=0.
//     - done_valid arrives exactly 5 cycles later than in test 1.
//  3. abort during round 10 ->
//     - next cycle: state IDLE, round_onehot=0, start_ready=1, no done_valid.
//     - A new start then runs the full 24 rounds.
//  4. reset asserted in round 5, then in DONE ->
//     - every output at its reset value next cycle.
//  5. start_valid held high continuously with done_ready=1 ->
//     - one start accepted per 26 cycles (24 RUN + 1 DONE + 1 IDLE).
//     - start_ready=0 throughout RUN and DONE.
//  6. Random stall/abort/start/done_ready for 10^5 cycles ->
//     - round_onehot always one-hot in RUN and zero elsewhere.
//     - each done_valid is preceded by exactly 24 round_en cycles since the last accepted
//       start.

Source files
------------

// File: rtl/keccak_round_sequencer.sv
// Round-loop sequencer for the SHA-3 permutation: one start walks a one-hot index through ROUNDS rounds.
// Latency: start at T -> round 0 at T+1, done_valid at T+ROUNDS+1 (+1 per stall cycle); done held until i_done_ready.
module keccak_round_sequencer #(
  parameter int ROUNDS = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start_valid,
  output logic              o_start_ready,
  input  logic              i_stall,
  input  logic              i_abort,
  output logic [ROUNDS-1:0] o_round_onehot,
  output logic              o_round_en,
  output logic              o_round_first,
  output logic              o_round_last,
  output logic              o_busy,
  output logic              o_done_valid,
  input  logic              i_done_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROUNDS-1:0] r_onehot;
  logic [ROUNDS-1:0] w_onehot_nxt;
  logic              w_round_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_onehot <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_onehot <= w_onehot_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_onehot_nxt  = r_onehot;
    w_round_en    = 1'b0;
    o_start_ready = 1'b0;
    o_done_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_start_ready = 1'b1;
        if (i_start_valid) begin
          w_state_nxt  = S_RUN;
          w_onehot_nxt = {{(ROUNDS-1){1'b0}}, 1'b1};
        end
      end
      S_RUN: begin
        w_round_en = ~i_stall;
        if (w_round_en) begin
          // Leave for DONE on the last round so the shift never wraps.
          if (r_onehot[ROUNDS-1]) begin
            w_state_nxt  = S_DONE;
            w_onehot_nxt = '0;
          end else begin
            w_onehot_nxt = {r_onehot[ROUNDS-2:0], 1'b0};
          end
        end
      end
      S_DONE: begin
        o_done_valid = 1'b1;
        if (i_done_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_onehot_nxt = '0;
      end
    endcase
    // Abort overrides every other request; the round issued this cycle is discarded downstream.
    if (i_abort) begin
      w_state_nxt  = S_IDLE;
      w_onehot_nxt = '0;
    end
  end

  assign o_round_onehot = r_onehot;
  assign o_round_en     = w_round_en;
  assign o_round_first  = r_onehot[0] & w_round_en;
  assign o_round_last   = r_onehot[ROUNDS-1] & w_round_en;
  assign o_busy         = (r_state != S_IDLE);

endmodule
